ring_monitor: RTL and testbench

- Downstream checker/decoder for the 8-bit one-hot rotate-left ring counter.
- Samples the counter output and the counter's init line every clock and verifies that each step is a legal single left rotation.
- Encodes the active bit position, counts full laps, and raises a re-init request when the ring is corrupted or uninitialised.
- Its reinit_req output drives the ring counter's init input through top-level glue.

---
 rtl/ring_pkg.sv | 19 +
 rtl/ring_monitor_onehot_enc.sv | 19 +
 rtl/ring_monitor.sv | 157 +++++++++++++++
 tb/tb_ring_monitor.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared types and constants for the one-hot ring counter checker.
package ring_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        FAULT = 2'd3
    } ring_state_e;

    localparam int                RING_W    = 8;
    localparam logic [RING_W-1:0] START_PAT = 8'b1000_0000;

    // One legal ring step: rotate left by one, MSB wraps into bit 0.
    function automatic logic [RING_W-1:0] rotl(input logic [RING_W-1:0] x);
        return {x[RING_W-2:0], x[RING_W-1]};
    endfunction

endpackage

// File: rtl/ring_monitor_onehot_enc.sv
// One-hot to binary index encoder. The input is assumed to be already
// validated as one-hot, so OR-ing the indices of the set bits is enough.
module onehot_enc #(
    parameter int WIDTH = 8,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IW-1:0]    idx
);

    // OR together the index of every set bit
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) idx = idx | IW'(i);
        end
    end

endmodule

// File: rtl/ring_monitor.sv
// Checker/decoder for a one-hot rotate-left ring counter. Verifies every
// step is a single left rotation, reports the active bit position, counts
// laps and requests re-initialisation when the ring is corrupt/unknown.
module ring_monitor
    import ring_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               LAP_W     = 16,
    parameter logic [WIDTH-1:0] START_PAT = {1'b1, {(WIDTH-1){1'b0}}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_in,
    input  logic [WIDTH-1:0]         ring_in,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     pos_valid,
    output logic                     lap_pulse,
    output logic [LAP_W-1:0]         lap_count,
    output logic                     err,
    output logic [7:0]               err_count,
    output logic                     reinit_req
);

    localparam int PW = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] rotl_w(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], x[WIDTH-1]};
    endfunction

    ring_state_e       state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [PW-1:0]     pos_q, pos_d;
    logic              pos_valid_q, pos_valid_d;
    logic              lap_pulse_q, lap_pulse_d;
    logic [LAP_W-1:0]  lap_count_q, lap_count_d;
    logic              err_q, err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              reinit_q, reinit_d;

    logic [PW-1:0]     enc_idx;
    logic              sync_ok;
    logic              step_ok;
    logic              at_start;
    logic [7:0]        err_count_inc;

    onehot_enc #(.WIDTH(WIDTH), .IW(PW)) u_enc (
        .onehot (ring_in),
        .idx    (enc_idx)
    );

    assign at_start      = (ring_in == START_PAT);
    assign sync_ok       = at_start;
    assign step_ok       = (ring_in == rotl_w(prev_q));
    assign err_count_inc = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: init always wins, otherwise sync/track checks
    always_comb begin
        state_d = state_q;
        if (init_in) begin
            state_d = SYNC;
        end else begin
            case (state_q)
                SYNC:    state_d = sync_ok ? TRACK : FAULT;
                TRACK:   state_d = step_ok ? TRACK : FAULT;
                default: state_d = state_q;
            endcase
        end
    end

    // Output/datapath next values; pulses default low each cycle
    always_comb begin
        prev_d      = prev_q;
        pos_d       = pos_q;
        pos_valid_d = pos_valid_q;
        lap_pulse_d = 1'b0;
        lap_count_d = lap_count_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        reinit_d    = reinit_q;
        if (init_in) begin
            // Ring loads START_PAT on this edge; whatever it shows now is not checked
            reinit_d    = 1'b0;
            pos_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: reinit_d = 1'b1;
                SYNC: begin
                    if (sync_ok) begin
                        prev_d      = ring_in;
                        pos_d       = PW'(WIDTH-1);
                        pos_valid_d = 1'b1;
                    end else begin
                        err_d       = 1'b1;
                        err_count_d = err_count_inc;
                        pos_valid_d = 1'b0;
                        reinit_d    = 1'b1;
                    end
                end
                TRACK: begin
                    if (step_ok) begin
                        prev_d = ring_in;
                        pos_d  = enc_idx;
                        if (at_start) begin
                            lap_pulse_d = 1'b1;
                            lap_count_d = lap_count_q + 1'b1;
                        end
                    end else begin
                        // prev is kept so the bad value never becomes a reference
                        err_d       = 1'b1;
                        err_count_d = err_count_inc;
                        pos_valid_d = 1'b0;
                        reinit_d    = 1'b1;
                    end
                end
                default: reinit_d = 1'b1;
            endcase
        end
    end

    // Datapath/output registers; reinit_req comes out of reset asserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= '0;
            pos_q       <= '0;
            pos_valid_q <= 1'b0;
            lap_pulse_q <= 1'b0;
            lap_count_q <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            reinit_q    <= 1'b1;
        end else begin
            prev_q      <= prev_d;
            pos_q       <= pos_d;
            pos_valid_q <= pos_valid_d;
            lap_pulse_q <= lap_pulse_d;
            lap_count_q <= lap_count_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            reinit_q    <= reinit_d;
        end
    end

    assign pos        = pos_q;
    assign pos_valid  = pos_valid_q;
    assign lap_pulse  = lap_pulse_q;
    assign lap_count  = lap_count_q;
    assign err        = err_q;
    assign err_count  = err_count_q;
    assign reinit_req = reinit_q;

endmodule

// File: tb/tb_ring_monitor.sv
// Scoreboard bench for ring_monitor: stimulus pushes the expected
// post-edge outputs, a monitor pops and compares one cycle later.
module tb_ring_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_in = 1'b0;
    logic [7:0]  ring_in = 8'h00;
    logic [2:0]  pos;
    logic        pos_valid;
    logic        lap_pulse;
    logic [15:0] lap_count;
    logic        err;
    logic [7:0]  err_count;
    logic        reinit_req;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0]  pos;
        logic        pv;
        logic        lp;
        logic [15:0] lc;
        logic        e;
        logic [7:0]  ec;
        logic        rr;
    } exp_t;

    exp_t sb_q[$];

    ring_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .init_in    (init_in),
        .ring_in    (ring_in),
        .pos        (pos),
        .pos_valid  (pos_valid),
        .lap_pulse  (lap_pulse),
        .lap_count  (lap_count),
        .err        (err),
        .err_count  (err_count),
        .reinit_req (reinit_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic chk_all(input exp_t x);
        chk("pos",        16'(pos),        16'(x.pos));
        chk("pos_valid",  16'(pos_valid),  16'(x.pv));
        chk("lap_pulse",  16'(lap_pulse),  16'(x.lp));
        chk("lap_count",  lap_count,       x.lc);
        chk("err",        16'(err),        16'(x.e));
        chk("err_count",  16'(err_count),  16'(x.ec));
        chk("reinit_req", 16'(reinit_req), 16'(x.rr));
    endtask

    // Monitor: every cycle the DUT presents registered outputs; check if one is owed
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) chk_all(sb_q.pop_front());
    end

    // Drive one cycle of stimulus and record what must appear after the edge
    task automatic step(input logic ini, input logic [7:0] r, input logic [2:0] p,
                        input logic pv, input logic lp, input logic [15:0] lc,
                        input logic e, input logic [7:0] ec, input logic rr);
        exp_t x;
        @(negedge clk);
        init_in = ini;
        ring_in = r;
        x = '{pos: p, pv: pv, lp: lp, lc: lc, e: e, ec: ec, rr: rr};
        sb_q.push_back(x);
    endtask

    logic [7:0] trk_seq [9];
    logic [2:0] trk_pos [9];
    logic [7:0] ec_e;

    initial begin
        trk_seq = '{8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        trk_pos = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

        // Reset values
        #12;
        chk_all('{pos: 3'd0, pv: 1'b0, lp: 1'b0, lc: 16'd0, e: 1'b0, ec: 8'd0, rr: 1'b1});
        @(negedge clk);
        rst = 1'b0;

        // Uninitialised ring: stays IDLE, keeps requesting init, no errors
        step(0, 8'h5A, 0, 0, 0, 0, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
        step(0, 8'hFF, 0, 0, 0, 0, 0, 0, 1);
        step(0, 8'h03, 0, 0, 0, 0, 0, 0, 1);
        step(0, 8'h80, 0, 0, 0, 0, 0, 0, 1);

        // Init then one full legal lap
        step(1, 8'h33, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            step(0, trk_seq[i], trk_pos[i], 1, (i == 8), (i == 8) ? 16'd1 : 16'd0, 0, 0, 0);

        // Skip a position: error once, then silent in FAULT
        step(0, 8'h01, 0, 1, 0, 1, 0, 0, 0);
        step(0, 8'h02, 1, 1, 0, 1, 0, 0, 0);
        step(0, 8'h08, 1, 0, 0, 1, 1, 1, 1);
        step(0, 8'hFF, 1, 0, 0, 1, 0, 1, 1);
        step(0, 8'h00, 1, 0, 0, 1, 0, 1, 1);

        // Corrupt value coincident with init is ignored
        step(1, 8'h00, 1, 0, 0, 1, 0, 1, 0);
        step(0, 8'h80, 7, 1, 0, 1, 0, 1, 0);
        step(0, 8'h01, 0, 1, 0, 1, 0, 1, 0);
        step(1, 8'h00, 0, 0, 0, 1, 0, 1, 0);
        step(0, 8'h80, 7, 1, 0, 1, 0, 1, 0);

        // Bad start pattern in SYNC, repeated until err_count saturates
        ec_e = 8'd1;
        for (int k = 0; k < 300; k++) begin
            step(1, 8'h00, 7, 0, 0, 1, 0, ec_e, 0);
            ec_e = (ec_e == 8'hFF) ? 8'hFF : ec_e + 8'd1;
            step(0, 8'h81, 7, 0, 0, 1, 1, ec_e, 1);
        end
        step(0, 8'h00, 7, 0, 0, 1, 0, 8'hFF, 1);

        // Mid-lap asynchronous reset
        step(1, 8'h00, 7, 0, 0, 1, 0, 8'hFF, 0);
        step(0, 8'h80, 7, 1, 0, 1, 0, 8'hFF, 0);
        step(0, 8'h01, 0, 1, 0, 1, 0, 8'hFF, 0);
        step(0, 8'h02, 1, 1, 0, 1, 0, 8'hFF, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all('{pos: 3'd0, pv: 1'b0, lp: 1'b0, lc: 16'd0, e: 1'b0, ec: 8'd0, rr: 1'b1});
        @(negedge clk);
        rst = 1'b0;
        init_in = 1'b0;
        ring_in = 8'h04;
        step(0, 8'h04, 0, 0, 0, 0, 0, 0, 1);

        @(posedge clk);
        #2;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
